i2c_tx_byte_reader: RTL
=======================

I2C_TX_BYTE_READER -- requirements
Module: i2c_tx_byte_reader

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8: byte width read from the TX FIFO and serialized.
REQ-002 SHALL have parameter COUNT_SIZE, default 8: width of the acknowledged-byte counter.
REQ-003 clock_i  input  1  single clock; all logic rising-edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 fifo_data_i  input  DATA_SIZE  head-of-FIFO data, valid while fifo_empty_i=0.
REQ-006 fifo_empty_i  input  1  TX FIFO empty.
REQ-007 fifo_read_inc_o  output  1  one-cycle pop strobe to the FIFO read side.
REQ-008 byte_req_i  input  1  master FSM requests the next byte.
REQ-009 bit_req_i  input  1  bit-timer strobe: current bit consumed, advance.
REQ-010 abort_i  input  1  stop or arbitration loss; return to idle.
REQ-011 ack_valid_i  input  1  strobe: ack_i is sampled this cycle.
REQ-012 ack_i  input  1  sampled SDA in the ACK slot (0 = ACK, 1 = NACK).
REQ-013 clear_count_i  input  1  clears byte_count_o.
REQ-014 sda_bit_o  output  1  bit to drive on SDA (1 = released).
REQ-015 in_ack_slot_o  output  1  high while in the ACK state.
REQ-016 busy_o  output  1  high when the state is not IDLE.
REQ-017 done_o  output  1  one-cycle pulse at the end of a byte plus ACK slot.
REQ-018 nack_o  output  1  one-cycle pulse, coincident with done_o, on NACK.
REQ-019 underrun_o  output  1  one-cycle pulse when a byte is requested from an empty FIFO.
REQ-020 byte_count_o  output  COUNT_SIZE  count of ACKed bytes.

Function
REQ-021 SHALL implement the states IDLE, SHIFT and ACK.
REQ-022 IDLE, on byte_req_i=1 with fifo_empty_i=0: at that edge, capture fifo_data_i into the shift register, load the bit counter with DATA_SIZE, and go to SHIFT; fifo_read_inc_o is high for exactly the next cycle.
REQ-023 IDLE, on byte_req_i=1 with fifo_empty_i=1: no pop, underrun_o pulses in the next cycle, stay in IDLE.
REQ-024 SHIFT: sda_bit_o is the shift-register MSB; each bit_req_i shifts left by one and decrements the counter; the bit_req_i that consumes the last bit moves the state to ACK.
REQ-025 Bit order is MSB first; exactly DATA_SIZE bit_req_i strobes per byte.
REQ-026 ACK: sda_bit_o=1 and in_ack_slot_o=1; bit_req_i is ignored; the block waits indefinitely for ack_valid_i.
REQ-027 ACK, on ack_valid_i=1: done_o pulses and the state goes to IDLE. If ack_i=0, byte_count_o increments, saturating at all-ones. If ack_i=1, nack_o pulses and there is no increment.
REQ-028 In IDLE, sda_bit_o=1.
REQ-029 byte_req_i outside IDLE SHALL be ignored; one byte is in flight at most.
REQ-030 abort_i=1 in any state: the state is IDLE at the next edge, sda_bit_o=1, and no done_o or nack_o; a byte already popped is discarded, not re-queued.
REQ-031 Simultaneous events:
- abort_i beats byte_req_i, bit_req_i and ack_valid_i.
- clear_count_i beats an increment in the same cycle (result 0).
REQ-032 All outputs SHALL be registered except sda_bit_o, in_ack_slot_o and busy_o, which decode from registered state.

Reset
REQ-033 While reset_i=1: state IDLE, shift register 0, bit counter 0, byte_count_o 0.
REQ-034 While reset_i=1: fifo_read_inc_o, done_o, nack_o and underrun_o are 0; sda_bit_o is 1.
REQ-035 Reset asserted mid-byte SHALL behave as abort_i, with byte_count_o additionally cleared.

Structure
REQ-036 The state encodings and the DATA_SIZE and COUNT_SIZE defaults SHALL live in the shared i2c package used by the FIFO and master blocks.
REQ-037 A single sub-module, i2c_shift_counter (loadable shift register plus down-counter), is permitted; the FSM stays in the top.

Verification
REQ-038 FIFO holds 0xA5, ACK:
- stimulus: byte_req_i, 8 bit_req_i, then ack_valid_i with ack_i=0;
- response: fifo_read_inc_o one pulse; sda_bit_o sequence 1,0,1,0,0,1,0,1; done_o=1; nack_o=0; byte_count_o=1.
REQ-039 NACK: FIFO holds 0x3C, ack_i=1 -> nack_o and done_o pulse together; byte_count_o unchanged.
REQ-040 Empty FIFO plus byte_req_i -> underrun_o single pulse; fifo_read_inc_o=0; busy_o=0.
REQ-041 abort_i after the 3rd bit_req_i -> IDLE next cycle; sda_bit_o=1; no done_o; next byte_req_i pops the following FIFO entry.
REQ-042 byte_count_o at 255 plus ACK -> stays 255; clear_count_i together with ACK -> 0.
REQ-043 reset_i asserted while in ACK -> all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/i2c_tx_byte_reader_pkg.sv
// ---------------------------------------------------------------------------
// i2c_tx_byte_reader_pkg
// Shared I2C definitions for the TX path (FIFO, byte reader, master FSM):
//   - reader_state_e : state encoding of the TX byte reader
//   - DATA_SIZE_DEF  : default byte width
//   - COUNT_SIZE_DEF : default width of the acknowledged-byte counter
//   - bit_cnt_width(): width needed for a down-counter that holds 0..n
// ---------------------------------------------------------------------------
package i2c_tx_byte_reader_pkg;

    localparam int DATA_SIZE_DEF  = 8;
    localparam int COUNT_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ACK   = 2'd2
    } reader_state_e;

    // The bit counter is loaded with the full byte width, so it must be able
    // to represent n itself, not just n-1.
    function automatic int bit_cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/i2c_tx_byte_reader_if.sv
// ---------------------------------------------------------------------------
// i2c_tx_byte_reader_if
// Bundles every non-clock/non-reset signal of the TX byte reader.
// Signal suffixes are from the reader's point of view (_i into the reader,
// _o out of it).
//   slave  modport : the byte reader itself
//   master modport : the surrounding FIFO / master FSM (or a testbench)
// ---------------------------------------------------------------------------
interface i2c_tx_byte_reader_if
    import i2c_tx_byte_reader_pkg::*;
#(
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int COUNT_SIZE = COUNT_SIZE_DEF
);
    // FIFO read side
    logic [DATA_SIZE-1:0]  fifo_data_i;
    logic                  fifo_empty_i;
    logic                  fifo_read_inc_o;
    // Master FSM handshake
    logic                  byte_req_i;
    logic                  bit_req_i;
    logic                  abort_i;
    logic                  ack_valid_i;
    logic                  ack_i;
    logic                  clear_count_i;
    // Reader outputs
    logic                  sda_bit_o;
    logic                  in_ack_slot_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  nack_o;
    logic                  underrun_o;
    logic [COUNT_SIZE-1:0] byte_count_o;

    modport slave (
        input  fifo_data_i, fifo_empty_i,
        input  byte_req_i, bit_req_i, abort_i, ack_valid_i, ack_i, clear_count_i,
        output fifo_read_inc_o, sda_bit_o, in_ack_slot_o, busy_o,
        output done_o, nack_o, underrun_o, byte_count_o
    );

    modport master (
        output fifo_data_i, fifo_empty_i,
        output byte_req_i, bit_req_i, abort_i, ack_valid_i, ack_i, clear_count_i,
        input  fifo_read_inc_o, sda_bit_o, in_ack_slot_o, busy_o,
        input  done_o, nack_o, underrun_o, byte_count_o
    );

endinterface

// File: rtl/i2c_shift_counter.sv
// ---------------------------------------------------------------------------
// i2c_shift_counter
// Loadable MSB-first shift register plus a bit down-counter.
//   clk_i   : clock
//   srst_i  : synchronous active-high reset (register and counter to 0)
//   load_i  : capture data_i and load the counter with DATA_SIZE
//   shift_i : shift left by one (zero fill) and decrement the counter
//   data_i  : parallel load data
//   msb_o   : current shift-register MSB (bit on the wire)
//   last_o  : exactly one bit remains to be consumed
// load_i has priority over shift_i.
// ---------------------------------------------------------------------------
module i2c_shift_counter #(
    parameter int DATA_SIZE = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [DATA_SIZE-1:0] data_i,
    output logic                 msb_o,
    output logic                 last_o
);

    logic [DATA_SIZE-1:0] shreg_q;
    logic [DATA_SIZE-1:0] shreg_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    // Per-bit next value: parallel load, shift from the neighbour below, or hold.
    for (genvar gi = 0; gi < DATA_SIZE; gi++) begin : g_bit
        logic shift_in;
        if (gi == 0) begin : g_lsb
            assign shift_in = 1'b0;
        end else begin : g_upper
            assign shift_in = shreg_q[gi-1];
        end
        assign shreg_d[gi] = load_i  ? data_i[gi] :
                             shift_i ? shift_in   : shreg_q[gi];
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(DATA_SIZE);
        end else if (shift_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign msb_o  = shreg_q[DATA_SIZE-1];
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/i2c_tx_byte_reader.sv
// ---------------------------------------------------------------------------
// i2c_tx_byte_reader
// Pulls one byte from the TX FIFO on request, serializes it MSB first on
// bit-timer strobes, then waits in the ACK slot for the sampled ACK/NACK.
// Counts ACKed bytes (saturating).
//   clock_i : clock, all logic on the rising edge
//   reset_i : synchronous active-high reset
//   bus     : i2c_tx_byte_reader_if.slave
//             FIFO   : fifo_data_i, fifo_empty_i -> fifo_read_inc_o
//             control: byte_req_i, bit_req_i, abort_i, ack_valid_i, ack_i,
//                      clear_count_i
//             status : sda_bit_o, in_ack_slot_o, busy_o (decoded from state)
//                      done_o, nack_o, underrun_o, byte_count_o (registered)
// ---------------------------------------------------------------------------
module i2c_tx_byte_reader
    import i2c_tx_byte_reader_pkg::*;
#(
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int COUNT_SIZE = COUNT_SIZE_DEF
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    i2c_tx_byte_reader_if.slave   bus
);

    localparam int BIT_CNT_W = bit_cnt_width(DATA_SIZE);

    reader_state_e          state_q;
    reader_state_e          state_d;
    logic                   read_inc_q;
    logic                   read_inc_d;
    logic                   done_q;
    logic                   done_d;
    logic                   nack_q;
    logic                   nack_d;
    logic                   underrun_q;
    logic                   underrun_d;
    logic [COUNT_SIZE-1:0]  byte_count_q;
    logic [COUNT_SIZE-1:0]  byte_count_d;

    logic                   sc_load;
    logic                   sc_shift;
    logic                   sc_msb;
    logic                   sc_last;

    i2c_shift_counter #(
        .DATA_SIZE (DATA_SIZE),
        .CNT_W     (BIT_CNT_W)
    ) u_shift_counter (
        .clk_i   (clock_i),
        .srst_i  (reset_i),
        .load_i  (sc_load),
        .shift_i (sc_shift),
        .data_i  (bus.fifo_data_i),
        .msb_o   (sc_msb),
        .last_o  (sc_last)
    );

    // Next-state and strobe decode. abort_i overrides every other event;
    // a byte already popped is simply dropped.
    always_comb begin
        state_d      = state_q;
        read_inc_d   = 1'b0;
        done_d       = 1'b0;
        nack_d       = 1'b0;
        underrun_d   = 1'b0;
        byte_count_d = byte_count_q;
        sc_load      = 1'b0;
        sc_shift     = 1'b0;

        if (bus.abort_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.byte_req_i) begin
                        if (!bus.fifo_empty_i) begin
                            sc_load    = 1'b1;
                            read_inc_d = 1'b1;
                            state_d    = ST_SHIFT;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bus.bit_req_i) begin
                        sc_shift = 1'b1;
                        if (sc_last) begin
                            state_d = ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (bus.ack_valid_i) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        if (bus.ack_i) begin
                            nack_d = 1'b1;
                        end else if (byte_count_q != {COUNT_SIZE{1'b1}}) begin
                            byte_count_d = byte_count_q + COUNT_SIZE'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Clearing the counter wins over a same-cycle increment.
        if (bus.clear_count_i) begin
            byte_count_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            read_inc_q   <= 1'b0;
            done_q       <= 1'b0;
            nack_q       <= 1'b0;
            underrun_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            read_inc_q   <= read_inc_d;
            done_q       <= done_d;
            nack_q       <= nack_d;
            underrun_q   <= underrun_d;
            byte_count_q <= byte_count_d;
        end
    end

    // SDA is released (1) everywhere except while shifting data bits.
    assign bus.sda_bit_o       = (state_q == ST_SHIFT) ? sc_msb : 1'b1;
    assign bus.in_ack_slot_o   = (state_q == ST_ACK);
    assign bus.busy_o          = (state_q != ST_IDLE);
    assign bus.fifo_read_inc_o = read_inc_q;
    assign bus.done_o          = done_q;
    assign bus.nack_o          = nack_q;
    assign bus.underrun_o      = underrun_q;
    assign bus.byte_count_o    = byte_count_q;

endmodule
